band_peak_tracker: RTL and testbench

- Parametrised successor of the maxima-finding stage in the shazam fingerprint chain.
- Consumes the per-bin magnitude stream that follows the magnitude block, once per FFT frame.
- Tracks the strongest bin in each of NUM_BANDS equal-width frequency bands.
- Double-buffers the per-frame result so the next frame accumulates while the previous one drains, one {bin, magnitude} word per band, over a valid/ready stream to the SPI packer.

---
 rtl/band_peak_tracker.sv | 134 +++++++++++++
 tb/tb_band_peak_tracker.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/band_peak_tracker.sv
// Per-band peak tracker: keeps the strongest bin of each frequency band per frame and
// drains the closed frame as one {bin, magnitude} word per band. Optional: BAND_PEAK_THRESHOLD_EN.
module band_peak_tracker #(
  parameter int BIN_W     = 9,
  parameter int MAG_W     = 16,
  parameter int NUM_BANDS = 16,
  parameter int SKIP_DC   = 1,
  localparam int BAND_W   = $clog2(NUM_BANDS)
) (
  input  logic                   MAX10_CLK1_50,
  input  logic                   reset_n,
`ifdef BAND_PEAK_THRESHOLD_EN
  input  logic [MAG_W-1:0]       mag_threshold,
`endif
  input  logic                   mag_valid,
  input  logic [BIN_W-1:0]       mag_bin,
  input  logic [MAG_W-1:0]       mag,
  input  logic                   mag_last,
  output logic                   peak_valid,
  input  logic                   peak_ready,
  output logic [BIN_W+MAG_W-1:0] peak_data,
  output logic [BAND_W-1:0]      peak_band,
  output logic                   peak_last,
  output logic [15:0]            frame_count,
  output logic                   overrun
);
  localparam int WORD_W = BIN_W + MAG_W;
  localparam int BW     = (1 << BIN_W) / NUM_BANDS;
  localparam logic [BAND_W-1:0] LAST_IDX = BAND_W'(NUM_BANDS - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e              state_q, state_d;
  logic [BAND_W-1:0]   idx_q, idx_d;
  logic [15:0]         fc_q, fc_d;
  logic                ovr_q, ovr_d;

  logic [BAND_W-1:0]   in_band;
  logic                dc_skip, close, final_hs, copy;
  logic [NUM_BANDS-1:0][WORD_W-1:0] words;

  assign in_band  = mag_bin[BIN_W-1 -: BAND_W];
  assign dc_skip  = (SKIP_DC != 0) && (mag_bin == '0);
  assign close    = mag_valid && mag_last;
  assign final_hs = (state_q == SEND) && peak_ready && (idx_q == LAST_IDX);
  // A bank emptied by this cycle's last handshake can take the closing frame at once.
  assign copy     = close && ((state_q == IDLE) || final_hs);

  for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
    localparam int CLR_I = ((SKIP_DC != 0) && (b == 0)) ? 1 : b * BW;
    localparam logic [BIN_W-1:0] CLR_BIN = CLR_I[BIN_W-1:0];

    logic [MAG_W-1:0] acc_mag_q, out_mag_q, fin_mag, cp_mag;
    logic [BIN_W-1:0] acc_bin_q, out_bin_q, fin_bin, cp_bin;
    logic             hit;

    // Strict compare: ties keep the earlier, lower bin.
    assign hit     = mag_valid && !dc_skip && (in_band == BAND_W'(b)) && (mag > acc_mag_q);
    assign fin_mag = hit ? mag     : acc_mag_q;
    assign fin_bin = hit ? mag_bin : acc_bin_q;

`ifdef BAND_PEAK_THRESHOLD_EN
    logic below;
    assign below  = fin_mag < mag_threshold;
    assign cp_mag = below ? '0      : fin_mag;
    assign cp_bin = below ? CLR_BIN : fin_bin;
`else
    assign cp_mag = fin_mag;
    assign cp_bin = fin_bin;
`endif

    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
      if (!reset_n) begin
        acc_mag_q <= '0;
        acc_bin_q <= CLR_BIN;
        out_mag_q <= '0;
        out_bin_q <= '0;
      end else begin
        if (close) begin
          acc_mag_q <= '0;
          acc_bin_q <= CLR_BIN;
        end else if (hit) begin
          acc_mag_q <= mag;
          acc_bin_q <= mag_bin;
        end
        if (copy) begin
          out_mag_q <= cp_mag;
          out_bin_q <= cp_bin;
        end
      end
    end

    assign words[b] = {out_bin_q, out_mag_q};
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fc_d    = fc_q;
    ovr_d   = ovr_q;
    if (final_hs) fc_d = fc_q + 16'd1;
    if (close && !copy) ovr_d = 1'b1;
    if (copy) begin
      state_d = SEND;
      idx_d   = '0;
    end else if (final_hs) begin
      state_d = IDLE;
      idx_d   = '0;
    end else if ((state_q == SEND) && peak_ready) begin
      idx_d   = idx_q + BAND_W'(1);
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      fc_q    <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fc_q    <= fc_d;
      ovr_q   <= ovr_d;
    end
  end

  assign peak_valid  = (state_q == SEND);
  assign peak_data   = (state_q == SEND) ? words[idx_q] : '0;
  assign peak_band   = idx_q;
  assign peak_last   = (state_q == SEND) && (idx_q == LAST_IDX);
  assign frame_count = fc_q;
  assign overrun     = ovr_q;
endmodule

// File: tb/tb_band_peak_tracker.sv
// Scoreboard bench for band_peak_tracker at default parameters (512 bins, 16 bands).
module tb_band_peak_tracker;
  localparam int NB = 512;

  typedef struct {
    logic [24:0] data;
    logic [3:0]  band;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mag_valid, mag_last, peak_ready;
  logic [8:0]  mag_bin;
  logic [15:0] mag;
  logic        peak_valid, peak_last, overrun;
  logic [24:0] peak_data;
  logic [3:0]  peak_band;
  logic [15:0] frame_count;
  logic [15:0] thr;

  logic [15:0] fm [NB];
  exp_t        sb [$];
  int          tests = 0;
  int          fails = 0;

  always #10 clk = ~clk;

  band_peak_tracker dut (
    .MAX10_CLK1_50(clk),
    .reset_n      (reset_n),
`ifdef BAND_PEAK_THRESHOLD_EN
    .mag_threshold(thr),
`endif
    .mag_valid    (mag_valid),
    .mag_bin      (mag_bin),
    .mag          (mag),
    .mag_last     (mag_last),
    .peak_valid   (peak_valid),
    .peak_ready   (peak_ready),
    .peak_data    (peak_data),
    .peak_band    (peak_band),
    .peak_last    (peak_last),
    .frame_count  (frame_count),
    .overrun      (overrun)
  );

  // Reference: per band, first strictly-greater magnitude wins; bin 0 never competes.
  task automatic push_frame();
    for (int k = 0; k < 16; k++) begin
      exp_t        e;
      logic [15:0] mx = 16'd0;
      int          base = k * 32;
      int          bn = (k == 0) ? 1 : base;
      int          clr = bn;
      for (int j = 0; j < 32; j++) begin
        int bi = base + j;
        if (bi != 0 && fm[bi] > mx) begin
          mx = fm[bi];
          bn = bi;
        end
      end
`ifdef BAND_PEAK_THRESHOLD_EN
      if (mx < thr) begin
        mx = 16'd0;
        bn = clr;
      end
`endif
      e.data = {bn[8:0], mx};
      e.band = k[3:0];
      e.last = (k == 15);
      sb.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    sb.delete();
  endtask

  task automatic feed_frame(input bit accept);
    for (int b = 0; b < NB; b++) begin
      @(negedge clk);
      mag_valid = 1'b1;
      mag_bin   = b[8:0];
      mag       = fm[b];
      mag_last  = (b == NB - 1);
    end
    if (accept) push_frame();
    @(negedge clk);
    mag_valid = 1'b0;
    mag_last  = 1'b0;
    tests++;
    if (accept && peak_valid !== 1'b1) begin
      fails++;
      $display("FAIL latency: peak_valid=%b required 1", peak_valid);
    end else if (!accept && overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: overrun=%b required 1", overrun);
    end
  endtask

  // Accepts n words with peak_ready high one cycle in every `period`, checking
  // each against the scoreboard and that stalled outputs do not move.
  task automatic drain(input int n, input int period, input string tag);
    int          got = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    logic [24:0] hd;
    logic [3:0]  hb;
    while (got < n && cyc < 2000) begin
      @(negedge clk);
      peak_ready = ((cyc % period) == 0);
      cyc++;
      if (peak_valid) begin
        if (stalled) begin
          tests++;
          if (peak_data !== hd || peak_band !== hb) begin
            fails++;
            $display("FAIL %s_stall: data=%h band=%0d required data=%h band=%0d",
                     tag, peak_data, peak_band, hd, hb);
          end
        end
        if (peak_ready) begin
          exp_t e;
          stalled = 1'b0;
          got++;
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL %s_extra: word data=%h band=%0d with none expected", tag, peak_data, peak_band);
          end else begin
            e = sb.pop_front();
            if (peak_data !== e.data || peak_band !== e.band || peak_last !== e.last) begin
              fails++;
              $display("FAIL %s_word: data=%h band=%0d last=%b required data=%h band=%0d last=%b",
                       tag, peak_data, peak_band, peak_last, e.data, e.band, e.last);
            end
          end
        end else begin
          stalled = 1'b1;
          hd = peak_data;
          hb = peak_band;
        end
      end
    end
    @(posedge clk);
    #1 peak_ready = 1'b0;
    tests++;
    if (got != n) begin
      fails++;
      $display("FAIL %s_timeout: words=%0d required %0d", tag, got, n);
    end
  endtask

  task automatic check_fc(input logic [15:0] exp_fc, input string tag);
    @(negedge clk);
    tests++;
    if (frame_count !== exp_fc) begin
      fails++;
      $display("FAIL %s_frame_count: got %0d required %0d", tag, frame_count, exp_fc);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    tests++;
    if (peak_valid !== 1'b0 || peak_data !== 25'd0 || peak_band !== 4'd0 ||
        peak_last !== 1'b0 || frame_count !== 16'd0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: v=%b d=%h b=%0d l=%b fc=%0d ovr=%b required all 0",
               peak_valid, peak_data, peak_band, peak_last, frame_count, overrun);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_constant();
    for (int b = 0; b < NB; b++) fm[b] = 16'd100;
    feed_frame(1'b1);
    drain(16, 1, "const");
    check_fc(16'd1, "const");
  endtask

  task automatic test_spike();
    for (int b = 0; b < NB; b++) fm[b] = 16'd10;
    fm[300] = 16'd5000;
    feed_frame(1'b1);
    drain(16, 1, "spike");
    check_fc(16'd2, "spike");
  endtask

  task automatic test_back_to_back_backpressure();
    for (int b = 0; b < NB; b++) fm[b] = 16'($urandom_range(0, 4000));
    fm[37] = 16'd9000;
    fm[38] = 16'd9000;
    feed_frame(1'b1);
    drain(16, 3, "bp");
    check_fc(16'd3, "bp");
  endtask

  task automatic test_overrun();
    int extra = 0;
    for (int b = 0; b < NB; b++) fm[b] = 16'($urandom_range(1, 60000));
    feed_frame(1'b1);
    drain(11, 1, "ovr1");
    for (int b = 0; b < NB; b++) fm[b] = 16'hFFFF;
    feed_frame(1'b0);
    drain(5, 1, "ovr2");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      peak_ready = 1'b1;
      if (peak_valid) extra++;
    end
    peak_ready = 1'b0;
    tests++;
    if (extra != 0) begin
      fails++;
      $display("FAIL overrun_dropped: saw %0d cycles of words, required 0", extra);
    end
    check_fc(16'd4, "ovr");
    tests++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_sticky: overrun=%b required 1", overrun);
    end
  endtask

  task automatic test_coincident();
    do_reset();
    for (int b = 0; b < NB; b++) fm[b] = 16'($urandom_range(0, 3000));
    feed_frame(1'b1);
    for (int b = 0; b < NB; b++) fm[b] = 16'(b * 7 + 3);
    for (int b = 0; b < NB; b++) begin
      @(negedge clk);
      mag_valid  = 1'b1;
      mag_bin    = b[8:0];
      mag        = fm[b];
      mag_last   = (b == NB - 1);
      peak_ready = (b < 15) || (b == NB - 1);
      if (peak_valid && peak_ready) begin
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL coin_extra: word data=%h band=%0d with none expected", peak_data, peak_band);
        end else begin
          e = sb.pop_front();
          if (peak_data !== e.data || peak_band !== e.band || peak_last !== e.last) begin
            fails++;
            $display("FAIL coin_word: data=%h band=%0d last=%b required data=%h band=%0d last=%b",
                     peak_data, peak_band, peak_last, e.data, e.band, e.last);
          end
        end
      end
    end
    push_frame();
    @(negedge clk);
    mag_valid  = 1'b0;
    mag_last   = 1'b0;
    peak_ready = 1'b0;
    tests++;
    if (overrun !== 1'b0 || peak_valid !== 1'b1 || peak_band !== 4'd0 || frame_count !== 16'd1) begin
      fails++;
      $display("FAIL coin_state: ovr=%b v=%b band=%0d fc=%0d required ovr=0 v=1 band=0 fc=1",
               overrun, peak_valid, peak_band, frame_count);
    end
    drain(16, 1, "coin2");
    check_fc(16'd2, "coin");
  endtask

  task automatic test_reset_midsend();
    for (int b = 0; b < NB; b++) fm[b] = 16'($urandom_range(0, 50000));
    feed_frame(1'b1);
    drain(7, 1, "rst1");
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests++;
    if (peak_valid !== 1'b0 || frame_count !== 16'd0 || peak_data !== 25'd0 ||
        peak_band !== 4'd0 || peak_last !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset_async: v=%b fc=%0d d=%h b=%0d l=%b ovr=%b required all 0",
               peak_valid, frame_count, peak_data, peak_band, peak_last, overrun);
    end
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    for (int b = 0; b < NB; b++) fm[b] = 16'd300;
    for (int b = 96; b < 128; b++) fm[b] = 16'd150;
`ifdef BAND_PEAK_THRESHOLD_EN
    thr = 16'd200;
`endif
    feed_frame(1'b1);
    tests++;
    if (peak_band !== 4'd0) begin
      fails++;
      $display("FAIL reset_restart_band: band=%0d required 0", peak_band);
    end
    drain(16, 1, "rst2");
    check_fc(16'd1, "rst");
    thr = 16'd0;
  endtask

  initial begin
    reset_n    = 1'b0;
    mag_valid  = 1'b0;
    mag_last   = 1'b0;
    mag_bin    = '0;
    mag        = '0;
    peak_ready = 1'b0;
    thr        = 16'd0;
    test_reset();
    test_constant();
    test_spike();
    test_back_to_back_backpressure();
    test_overrun();
    test_coincident();
    test_reset_midsend();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL leftover: %0d expected words never produced", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
